cache_port_arbiter: RTL
=======================

# cache_port_arbiter

Shares one cache's upstream request port among `N_REQ` requesters, such as ray-pipeline units that need scene data from the same cache. Grants are round-robin. The requester ID is carried in the top bits of the cache sideband, so each in-order cache response is routed back to the unit that issued it. A per-requester outstanding-request limit keeps one unit from filling the cache's internal FIFOs. The block sits between the requesting units and the `cache` upstream/downstream ports; the miss handler side of the cache is untouched.

## Interface
- `N_REQ`, 4: number of requesters (power of two, at least 2).
- `ADDR_W`, 16: cache address width.
- `SIDE_W`, 8: cache sideband width.
- `RDATA_W`, 288: cache read-data width.
- `MAX_OUT`, 4: maximum in-flight requests per requester.
- Derived localparams: `ID_W`=clog2(`N_REQ`); `USB_W`=`SIDE_W`-`ID_W`; `CNT_W`=clog2(`MAX_OUT`+1).

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `rq_valid`, in, `N_REQ`: per-requester request valid.
- `rq_addr`, in, `N_REQ`×`ADDR_W`: per-requester address.
- `rq_sb`, in, `N_REQ`×`USB_W`: per-requester sideband.
- `rq_stall`, out, `N_REQ`: low only in the cycle requester i is granted.
- `us_valid`, `us_addr`, `us_sb_data`, out, 1 / `ADDR_W` / `SIDE_W`: registered request to the cache.
- `us_stall`, in, 1: stall from the cache.
- `ds_valid`, `ds_rdata`, `ds_sb_data`, in, 1 / `RDATA_W` / `SIDE_W`: response from the cache.
- `ds_stall`, out, 1: stall to the cache.
- `rs_valid`, out, `N_REQ`: per-requester response valid.
- `rs_rdata`, `rs_sb`, out, `RDATA_W` / `USB_W`: broadcast response payload.
- `rs_stall`, in, `N_REQ`: per-requester response stall.
- `idle`, out, 1: all counters zero and `us_valid`=0.
- `err`, out, 1: sticky underflow flag.

## Operation
- A transfer occurs on any valid/stall pair when valid=1 and stall=0.
- `eligible[i]` = `rq_valid[i]` & (`cnt[i]` < `MAX_OUT`).
- `can_issue` = !`us_valid` | !`us_stall`.
- Grant:
  - Granting happens only when `can_issue`=1.
  - The winner is the first eligible index scanning upward from `rr_ptr`, with wrap-around.
  - At most one grant per cycle; `rq_stall` = ~`grant` (one-hot).
- On a grant to i:
  - The output register loads `us_addr`=`rq_addr[i]` and `us_sb_data`={i[`ID_W`-1:0], `rq_sb[i]`}, and sets `us_valid`=1.
  - `rr_ptr` becomes (i+1) mod `N_REQ`.
  - `cnt[i]` increments.
- With no grant:
  - If the cache accepts the held request (`us_valid` & !`us_stall`), `us_valid` clears.
  - Otherwise the output register holds its contents unchanged.
- Response path (combinational):
  - `id` = `ds_sb_data[SIDE_W-1 -: ID_W]`.
  - `rs_valid[id]` = `ds_valid`; all other `rs_valid` bits are 0.
  - `rs_rdata` = `ds_rdata`; `rs_sb` = `ds_sb_data[USB_W-1:0]`.
  - `ds_stall` = `ds_valid` & `rs_stall[id]`.
- Counter update:
  - `cnt[id]` decrements when `ds_valid` & !`rs_stall[id]`.
  - A simultaneous grant to i and response to i leaves `cnt[i]` unchanged.
  - A response delivered with `cnt[id]`=0 sets `err` (cleared only by reset) and leaves the counter at 0; there is no wrap.
- Requester at limit: a requester with `cnt`=`MAX_OUT` and valid high is skipped. `rr_ptr` does not stop on it, so other requesters proceed.
- A stalled requester holds the response at the head of the cache output. This blocks all responses behind it, which is inherent to an in-order cache and is accepted. `MAX_OUT` bounds the damage.

## Timing
- Reset values (async, while `rst`=0):
  - `us_valid`=0, `us_addr`=0, `us_sb_data`=0.
  - `rr_ptr`=0, all `cnt`=0, `err`=0.
  - `rq_stall`=all 1s, `idle`=1.
  - `rs_valid`/`ds_stall` follow the combinational response path (0 when `ds_valid`=0).
- Request latency: a grant in cycle t puts the request on `us_*` in cycle t+1.
- Throughput: back-to-back grants, one per cycle, while `us_stall`=0.
- `us_stall`=1 with `us_valid`=1:
  - No grant, and `us_*` stays stable.
  - A grant resumes in the same cycle `us_stall` falls.
- Response latency: zero cycles from `ds_*` to `rs_*`.
- Reset mid-operation:
  - Pending requests are dropped.
  - Late responses from the cache are still routed, but they set `err` because the counters are 0.
  - Reset is legal only together with a cache reset.

## Structure
- Shared package `arb_pkg` holds:
  - the `id_w(n)` function;
  - a typedef for the sideband split {id, usb};
  - the default `N_REQ`/`MAX_OUT` constants.
- Sub-module `rr_picker`:
  - purely combinational;
  - inputs: `eligible` [`N_REQ`], `rr_ptr`, `en`;
  - outputs: one-hot `grant`, `any`, and encoded `idx`.
- Counters, output register and response routing live in `cache_port_arbiter`.

## Test plan
- **Single requester stream.** Requester 2 presents addr 0x0010..0x0013, `rq_sb` 0x05 on consecutive cycles, `us_stall`=0 → `us_sb_data`=0x85 with each address on the following cycle; `cnt[2]` reaches 4, then a 5th request stalls until a response to 2 is delivered.
- **Round-robin fairness.** All four requesters valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; `rq_stall` is one-hot low.
- **Cache stall.** `us_stall`=1 for 5 cycles with `us_valid`=1 → `us_addr` is stable, no `rq_stall` deasserts, and `rr_ptr` does not move; the grant happens in the cycle `us_stall` falls.
- **Response routing.** `ds_valid`=1 with `ds_sb_data`=0xC3 → `rs_valid`=4'b1000, `rs_sb`=0x03; holding `rs_stall[3]`=1 for 3 cycles → `ds_stall`=1 and `cnt[3]` is unchanged.
- **Simultaneous events.** Grant to 1 and response to 1 in the same cycle with `cnt[1]`=2 → `cnt[1]`=2; requester 1 at `MAX_OUT` with 0 and 2 valid → 1 is skipped.
- **Error and reset.** A response with id 0 while `cnt[0]`=0 → `err`=1 and it stays 1; assert `rst`=0 mid-stream → all outputs at their reset values immediately (async), and `idle`=1.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the cache port arbiter: default sizing, ID width helper
// and the sideband layout {requester id, user sideband}.
package arb_pkg;

    localparam int unsigned N_REQ_DEF   = 4;
    localparam int unsigned MAX_OUT_DEF = 4;
    localparam int unsigned SIDE_W_DEF  = 8;

    function automatic int unsigned id_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned ID_W_DEF  = id_w(N_REQ_DEF);
    localparam int unsigned USB_W_DEF = SIDE_W_DEF - ID_W_DEF;

    // Cache sideband as seen by the arbiter: id in the top bits, user bits below.
    typedef struct packed {
        logic [ID_W_DEF-1:0]  id;
        logic [USB_W_DEF-1:0] usb;
    } sb_split_t;

endpackage

// File: rtl/cache_port_if.sv
// Upstream request / downstream response port of the shared cache.
interface cache_port_if #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned SIDE_W  = 8,
    parameter int unsigned RDATA_W = 288
);

    logic               us_valid;
    logic [ADDR_W-1:0]  us_addr;
    logic [SIDE_W-1:0]  us_sb_data;
    logic               us_stall;

    logic               ds_valid;
    logic [RDATA_W-1:0] ds_rdata;
    logic [SIDE_W-1:0]  ds_sb_data;
    logic               ds_stall;

    modport master (
        output us_valid, us_addr, us_sb_data, ds_stall,
        input  us_stall, ds_valid, ds_rdata, ds_sb_data
    );

    modport slave (
        input  us_valid, us_addr, us_sb_data, ds_stall,
        output us_stall, ds_valid, ds_rdata, ds_sb_data
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible index at or above rr_ptr, wrapping.
module rr_picker
    import arb_pkg::*;
#(
    parameter  int unsigned N_REQ = N_REQ_DEF,
    localparam int unsigned ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [ID_W-1:0]  rr_ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic             any,
    output logic [ID_W-1:0]  idx
);

    logic [ID_W-1:0] scan;

    // N_REQ is a power of two, so the ID_W-bit add wraps naturally.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        scan  = '0;
        if (en) begin
            for (int k = 0; k < N_REQ; k++) begin
                scan = rr_ptr + ID_W'(k);
                if (!any && eligible[scan]) begin
                    any         = 1'b1;
                    idx         = scan;
                    grant[scan] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin sharing of one cache request port among N_REQ requesters, with
// id-tagged sideband routing of in-order responses and per-requester credit limits.
module cache_port_arbiter
    import arb_pkg::*;
#(
    parameter  int unsigned N_REQ   = N_REQ_DEF,
    parameter  int unsigned ADDR_W  = 16,
    parameter  int unsigned SIDE_W  = SIDE_W_DEF,
    parameter  int unsigned RDATA_W = 288,
    parameter  int unsigned MAX_OUT = MAX_OUT_DEF,
    localparam int unsigned ID_W    = id_w(N_REQ),
    localparam int unsigned USB_W   = SIDE_W - ID_W,
    localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               rq_valid,
    input  logic [N_REQ-1:0][ADDR_W-1:0]   rq_addr,
    input  logic [N_REQ-1:0][USB_W-1:0]    rq_sb,
    output logic [N_REQ-1:0]               rq_stall,
    cache_port_if.master                   cache,
    output logic [N_REQ-1:0]               rs_valid,
    output logic [RDATA_W-1:0]             rs_rdata,
    output logic [USB_W-1:0]               rs_sb,
    input  logic [N_REQ-1:0]               rs_stall,
    output logic                           idle,
    output logic                           err
);

    logic [N_REQ-1:0]            eligible;
    logic [N_REQ-1:0]            grant;
    logic                        any;
    logic [ID_W-1:0]             idx;
    logic [ID_W-1:0]             rr_ptr;
    logic                        can_issue;
    logic [N_REQ-1:0][CNT_W-1:0] cnt;
    logic [N_REQ-1:0][CNT_W-1:0] cnt_nxt;
    logic [ID_W-1:0]             rsp_id;
    logic                        rsp_take;
    logic [N_REQ-1:0]            dec;
    logic                        underflow;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = rq_valid[i] && (cnt[i] < CNT_W'(MAX_OUT));
        end
    end

    assign can_issue = !cache.us_valid || !cache.us_stall;

    // Gating with rst keeps every requester stalled while reset is held.
    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .en       (can_issue && rst),
        .grant    (grant),
        .any      (any),
        .idx      (idx)
    );

    assign rq_stall = ~grant;

    // Output register toward the cache; holds while stalled, clears once accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache.us_valid   <= 1'b0;
            cache.us_addr    <= '0;
            cache.us_sb_data <= '0;
            rr_ptr           <= '0;
        end else if (any) begin
            cache.us_valid   <= 1'b1;
            cache.us_addr    <= rq_addr[idx];
            cache.us_sb_data <= {idx, rq_sb[idx]};
            rr_ptr           <= idx + ID_W'(1);
        end else if (cache.us_valid && !cache.us_stall) begin
            cache.us_valid   <= 1'b0;
        end
    end

    // Response routing is purely combinational on the id in the sideband top bits.
    assign rsp_id = cache.ds_sb_data[SIDE_W-1 -: ID_W];

    always_comb begin
        rs_valid         = '0;
        rs_valid[rsp_id] = cache.ds_valid;
    end

    assign rs_rdata       = cache.ds_rdata;
    assign rs_sb          = cache.ds_sb_data[USB_W-1:0];
    assign cache.ds_stall = cache.ds_valid && rs_stall[rsp_id];
    assign rsp_take       = cache.ds_valid && !rs_stall[rsp_id];
    assign dec            = rsp_take ? (N_REQ'(1) << rsp_id) : '0;
    assign underflow      = rsp_take && (cnt[rsp_id] == '0);

    // Credit counters: grant and response to the same requester cancel out.
    always_comb begin
        cnt_nxt = cnt;
        for (int i = 0; i < N_REQ; i++) begin
            case ({grant[i], dec[i]})
                2'b10:   cnt_nxt[i] = cnt[i] + CNT_W'(1);
                2'b01:   if (cnt[i] != '0) cnt_nxt[i] = cnt[i] - CNT_W'(1);
                default: cnt_nxt[i] = cnt[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (underflow) err <= 1'b1;
        end
    end

    assign idle = (cnt == '0) && !cache.us_valid;

endmodule
